// File: rtl/ball_hit_detect.sv
// ball_hit_detect
//   Turns ball and paddle video into the feedback used by the horizontal
//   motion/direction logic: paddle hit strobes, a stretched hit tone and
//   the score/serve pulse generated when the ball leaves the playfield.
//
// Ports
//   clk7_159   in   pixel clock, sole clock
//   reset      in   synchronous, active-high reset
//   _hvid      in   ball horizontal video, active low
//   _vvid      in   ball vertical video, active low
//   pad1/pad2  in   left/right paddle video, active high
//   _hblank    in   horizontal blank, active low
//   vreset     in   one-cycle frame-start pulse
//   l / r      in   ball moving left / right
//   _attract   in   low = attract mode
//   _hit1/_hit2 out left/right paddle hit, active low, 1-cycle latency
//   hit_sound  out  stretched hit tone enable
//   sc         out  score/serve pulse, SC_LEN cycles
//   score_l    out  one-cycle: left player scores (ball exited right)
//   score_r    out  one-cycle: right player scores (ball exited left)
module ball_hit_detect #(
  parameter int HIT_SND_LEN = 114545,
  parameter int SC_LEN      = 455,
  parameter int CW          = 17
) (
  input  logic clk7_159,
  input  logic reset,
  input  logic _hvid,
  input  logic _vvid,
  input  logic pad1,
  input  logic pad2,
  input  logic _hblank,
  input  logic vreset,
  input  logic l,
  input  logic r,
  input  logic _attract,
  output logic _hit1,
  output logic _hit2,
  output logic hit_sound,
  output logic sc,
  output logic score_l,
  output logic score_r
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCORE = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] SND_LOAD = CW'(HIT_SND_LEN);
  localparam logic [CW-1:0] SC_LOAD  = CW'(SC_LEN);

  state_t        state_q, state_d;
  logic [CW-1:0] snd_cnt_q, snd_cnt_d;
  logic [CW-1:0] sc_cnt_q, sc_cnt_d;
  logic          h1_seen_q, h1_seen_d;
  logic          h2_seen_q, h2_seen_d;
  logic          miss_seen_q, miss_seen_d;
  logic          hit1_n_q, hit1_n_d;
  logic          hit2_n_q, hit2_n_d;
  logic          score_l_q, score_l_d;
  logic          score_r_q, score_r_d;

  logic ball, hit1, hit2, miss;
  logic h1_keep, h2_keep, trig;

  always_comb begin
    ball = ~_hvid & ~_vvid;
    hit1 = ball & pad1;
    hit2 = ball & pad2;
    miss = ~_hvid & ~_hblank;

    hit1_n_d = ~hit1;
    hit2_n_d = ~hit2;

    // vreset clears the per-frame flag before a same-cycle hit is judged,
    // so a coincidence on the frame-start pixel still triggers the tone.
    h1_keep   = h1_seen_q & ~vreset;
    h2_keep   = h2_seen_q & ~vreset;
    trig      = (hit1 & ~h1_keep) | (hit2 & ~h2_keep);
    h1_seen_d = h1_keep | hit1;
    h2_seen_d = h2_keep | hit2;

    snd_cnt_d = snd_cnt_q;
    if (trig) begin
      snd_cnt_d = SND_LOAD;
    end else if (snd_cnt_q != '0) begin
      snd_cnt_d = snd_cnt_q - ONE;
    end

    // A miss on the vreset cycle belongs to the frame that is starting.
    miss_seen_d = vreset ? miss : (miss_seen_q | miss);

    state_d   = state_q;
    sc_cnt_d  = sc_cnt_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          state_d   = S_SCORE;
          sc_cnt_d  = SC_LOAD;
          score_l_d = r & _attract;
          score_r_d = ~r & l & _attract;
        end
      end
      S_SCORE: begin
        // Leave on the last counted cycle so sc lasts exactly SC_LEN cycles.
        if (sc_cnt_q > ONE) begin
          sc_cnt_d = sc_cnt_q - ONE;
        end else begin
          sc_cnt_d = '0;
          state_d  = S_LOCK;
        end
      end
      S_LOCK: begin
        // The LOCK state is the lockout: release only after a whole frame
        // in which the ball never sat inside horizontal blanking.
        if (vreset && !miss_seen_q && !miss) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---- register stage ----
  always_ff @(posedge clk7_159) begin
    if (reset) begin
      state_q     <= S_IDLE;
      snd_cnt_q   <= '0;
      sc_cnt_q    <= '0;
      h1_seen_q   <= 1'b0;
      h2_seen_q   <= 1'b0;
      miss_seen_q <= 1'b0;
      hit1_n_q    <= 1'b1;
      hit2_n_q    <= 1'b1;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snd_cnt_q   <= snd_cnt_d;
      sc_cnt_q    <= sc_cnt_d;
      h1_seen_q   <= h1_seen_d;
      h2_seen_q   <= h2_seen_d;
      miss_seen_q <= miss_seen_d;
      hit1_n_q    <= hit1_n_d;
      hit2_n_q    <= hit2_n_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
    end
  end

  assign _hit1     = hit1_n_q;
  assign _hit2     = hit2_n_q;
  assign hit_sound = (snd_cnt_q != '0) & _attract;
  assign sc        = (state_q == S_SCORE);
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;

endmodule

// File: tb/tb_ball_hit_detect.sv
// Directed bench for ball_hit_detect with HIT_SND_LEN=16, SC_LEN=8.
module tb_ball_hit_detect;

  logic clk = 1'b0;
  logic reset;
  logic hvid_n, vvid_n, pad1, pad2, hblank_n, vreset, l, r, attract_n;
  logic hit1_n, hit2_n, hit_sound, sc, score_l, score_r;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ball_hit_detect #(
    .HIT_SND_LEN(16),
    .SC_LEN     (8),
    .CW         (17)
  ) dut (
    .clk7_159 (clk),
    .reset    (reset),
    ._hvid    (hvid_n),
    ._vvid    (vvid_n),
    .pad1     (pad1),
    .pad2     (pad2),
    ._hblank  (hblank_n),
    .vreset   (vreset),
    .l        (l),
    .r        (r),
    ._attract (attract_n),
    ._hit1    (hit1_n),
    ._hit2    (hit2_n),
    .hit_sound(hit_sound),
    .sc       (sc),
    .score_l  (score_l),
    .score_r  (score_r)
  );

  typedef struct {
    logic hvid_n, vvid_n, pad1, vreset;
    logic e_hit1_n, e_snd;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    hvid_n = 1'b1; vvid_n = 1'b1; pad1 = 1'b0; pad2 = 1'b0;
    hblank_n = 1'b1; vreset = 1'b0; l = 1'b0; r = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic h1, input logic h2,
                         input logic snd, input logic s, input logic sl,
                         input logic sr);
    chk({tag, " _hit1"}, hit1_n, h1);
    chk({tag, " _hit2"}, hit2_n, h2);
    chk({tag, " hit_sound"}, hit_sound, snd);
    chk({tag, " sc"}, sc, s);
    chk({tag, " score_l"}, score_l, sl);
    chk({tag, " score_r"}, score_r, sr);
  endtask

  // One-cycle miss (ball horizontal window inside blanking), then idle.
  task automatic miss_tick(input logic ml, input logic mr);
    hvid_n = 1'b0; hblank_n = 1'b0; l = ml; r = mr;
    tick();
    idle_in();
  endtask

  initial begin
    // ---------------- reset ----------------
    idle_in();
    attract_n = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- pad1 hits, three lines in one frame ----------------
    // Lines at rows 1-4, 9-12, 20-23; tone from the first hit only (rows 1-16).
    // Row 24: ball without paddle; row 25: paddle with only _hvid low.
    for (int i = 0; i < 28; i++) begin
      logic hp;
      hp = (i >= 1 && i <= 4) || (i >= 9 && i <= 12) || (i >= 20 && i <= 23);
      tbl[i].vreset   = (i == 0);
      tbl[i].hvid_n   = ~(hp || i == 24 || i == 25);
      tbl[i].vvid_n   = ~(hp || i == 24);
      tbl[i].pad1     = hp || i == 25;
      tbl[i].e_hit1_n = ~hp;
      tbl[i].e_snd    = (i >= 1 && i <= 16);
    end
    for (int i = 0; i < 28; i++) begin
      hvid_n = tbl[i].hvid_n;
      vvid_n = tbl[i].vvid_n;
      pad1   = tbl[i].pad1;
      vreset = tbl[i].vreset;
      tick();
      chk($sformatf("tbl%0d _hit1", i), hit1_n, tbl[i].e_hit1_n);
      chk($sformatf("tbl%0d hit_sound", i), hit_sound, tbl[i].e_snd);
      chk($sformatf("tbl%0d sc", i), sc, 1'b0);
    end
    idle_in();

    // ---------------- retrigger in the next frame ----------------
    vreset = 1'b1;
    tick();
    vreset = 1'b0;
    hvid_n = 1'b0; vvid_n = 1'b0; pad2 = 1'b1;
    tick();
    chk_all("pad2 hit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_in();
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("snd run%0d", i), hit_sound, 1'b1);
    end
    hvid_n = 1'b0; vvid_n = 1'b0; pad1 = 1'b1;
    tick();
    chk("reload _hit1", hit1_n, 1'b0);
    chk("reload snd", hit_sound, 1'b1);
    idle_in();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("reload snd%0d", i), hit_sound, (i < 15) ? 1'b1 : 1'b0);
    end

    // vreset and hit on the same cycle: flag cleared then set, tone fires.
    vreset = 1'b1; hvid_n = 1'b0; vvid_n = 1'b0; pad1 = 1'b1;
    tick();
    chk("vres+hit _hit1", hit1_n, 1'b0);
    chk("vres+hit snd", hit_sound, 1'b1);
    idle_in();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("vres snd%0d", i), hit_sound, (i < 15) ? 1'b1 : 1'b0);
    end

    // ---------------- miss with r=1 ----------------
    miss_tick(1'b0, 1'b1);
    chk_all("miss r", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("sc run%0d", i), sc, (i < 7) ? 1'b1 : 1'b0);
      chk($sformatf("score_l once%0d", i), score_l, 1'b0);
    end
    // Frame A: miss mid-frame while locked.
    vreset = 1'b1; tick(); vreset = 1'b0;
    chk("lock A vres sc", sc, 1'b0);
    tick();
    miss_tick(1'b0, 1'b1);
    chk("lock A miss sc", sc, 1'b0);
    chk("lock A miss score_l", score_l, 1'b0);
    repeat (3) tick();
    // Frame B: miss coincident with vreset counts toward frame B.
    vreset = 1'b1; hvid_n = 1'b0; hblank_n = 1'b0; r = 1'b1;
    tick();
    idle_in();
    chk("lock B sc", sc, 1'b0);
    repeat (3) tick();
    // Frame C starts: B had a miss, so still locked; C is clean.
    vreset = 1'b1; tick(); vreset = 1'b0;
    chk("lock C sc", sc, 1'b0);
    repeat (3) tick();
    // Frame D starts after clean C: released.
    vreset = 1'b1; tick(); vreset = 1'b0;
    miss_tick(1'b1, 1'b0);
    chk_all("miss l", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("sc2 run%0d", i), sc, (i < 7) ? 1'b1 : 1'b0);
      chk($sformatf("score_r once%0d", i), score_r, 1'b0);
    end

    // ---------------- attract mode ----------------
    vreset = 1'b1; tick(); tick(); vreset = 1'b0;   // two clean frame starts
    attract_n = 1'b0;
    hvid_n = 1'b0; vvid_n = 1'b0; pad2 = 1'b1;
    tick();
    chk_all("attr hit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    tick();
    chk("attr snd", hit_sound, 1'b0);
    miss_tick(1'b0, 1'b1);
    chk_all("attr miss", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("attr sc%0d", i), sc, (i < 7) ? 1'b1 : 1'b0);
      chk($sformatf("attr snd%0d", i), hit_sound, 1'b0);
    end
    repeat (12) tick();                     // let the gated tone counter drain
    attract_n = 1'b1;
    tick();
    chk("attr drained snd", hit_sound, 1'b0);

    // ---------------- reset mid-SCORE ----------------
    vreset = 1'b1; tick(); tick(); vreset = 1'b0;
    miss_tick(1'b0, 1'b1);
    chk("rst sc1", sc, 1'b1);
    tick();
    chk("rst sc2", sc, 1'b1);
    tick();
    chk("rst sc3", sc, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("rst mid", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    miss_tick(1'b0, 1'b1);
    chk_all("post rst miss", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post rst sc%0d", i), sc, (i < 7) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
